// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch/data memory arbiter.
// Holds the FSM state and last-grant encodings, control constants and the
// wait-cycle load helper. Optional statistics build: MEM_ARB_STATS_EN.
package mem_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_t;

  typedef enum logic {
    ARB_GRANT_IF   = 1'b0,
    ARB_GRANT_DATA = 1'b1
  } arb_grant_t;

  localparam logic       RST_ENABLE    = 1'b1;
  localparam logic       CHIP_ENABLE   = 1'b1;
  localparam logic       CHIP_DISABLE  = 1'b0;
  localparam logic       WRITE_ENABLE  = 1'b1;
  localparam logic       WRITE_DISABLE = 1'b0;
  localparam logic [3:0] SEL_ALL       = 4'hF;
  localparam int         WAIT_MAX      = 15;

  // Clamp the wait-state parameter into the 4-bit counter range.
  function automatic logic [3:0] wait_load(input int cyc);
    if (cyc < 0)             return 4'd0;
    else if (cyc > WAIT_MAX) return 4'(WAIT_MAX);
    else                     return 4'(cyc);
  endfunction

endpackage

// File: rtl/arb_wait_cnt.sv
// Loadable 4-bit down-counter timing memory wait states.
// Latency: load/decrement visible the cycle after the strobe; zero is combinational.
// Backpressure: none; decrement stops at zero instead of wrapping.
// Ports: clk/rst, load + load_val, dec, cnt (current value), zero (cnt == 0).
module arb_wait_cnt
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] cnt,
  output logic       zero
);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between fetch and load/store ports.
// Latency: request seen in IDLE at cycle N -> mem_ce_o N+1..N+1+WAIT_CYC, ack at N+2+WAIT_CYC.
// Backpressure: requesters hold req until ack; stallreq_o is raised while any request is unserved.
// Ports: clk/rst, fetch port (if_*), data port (d_*), memory port (mem_*), stallreq_o.
// Optional build macro MEM_ARB_STATS_EN adds saturating grant/conflict counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 1
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_sel_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              stallreq_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_sel_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       if_grant_cnt_o,
  output logic [31:0]       d_grant_cnt_o,
  output logic [31:0]       conflict_cnt_o
`endif
);

  localparam logic [3:0] WAIT_LD = wait_load(WAIT_CYC);

  arb_state_t state;
  arb_grant_t last_grant;
  arb_grant_t cur_grant;

  logic       if_elig;
  logic       d_elig;
  logic       grant_any;
  logic       grant_data;
  logic       cnt_load;
  logic       cnt_dec;
  logic [3:0] cnt_val;
  logic       cnt_zero;

  // A port whose ack is on the wire this cycle may still be holding req;
  // it must not be re-granted on that stale request.
  assign if_elig = if_req_i & ~if_ack_o;
  assign d_elig  = d_req_i  & ~d_ack_o;

  assign grant_any  = if_elig | d_elig;
  // Data has priority unless it took the previous slot and fetch is waiting.
  assign grant_data = d_elig & ~((last_grant == ARB_GRANT_DATA) & if_elig);

  assign cnt_load = (state == ARB_IDLE) & grant_any;
  assign cnt_dec  = (state == ARB_ACCESS);

  arb_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WAIT_LD),
    .dec      (cnt_dec),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  assign stallreq_o = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state       <= ARB_IDLE;
      last_grant  <= ARB_GRANT_IF;
      cur_grant   <= ARB_GRANT_IF;
      if_rdata_o  <= '0;
      if_ack_o    <= 1'b0;
      d_rdata_o   <= '0;
      d_ack_o     <= 1'b0;
      mem_ce_o    <= CHIP_DISABLE;
      mem_we_o    <= WRITE_DISABLE;
      mem_sel_o   <= 4'h0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      // Acks are single-cycle pulses.
      if_ack_o <= 1'b0;
      d_ack_o  <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_any) begin
            state    <= ARB_ACCESS;
            mem_ce_o <= CHIP_ENABLE;
            if (grant_data) begin
              cur_grant   <= ARB_GRANT_DATA;
              last_grant  <= ARB_GRANT_DATA;
              mem_we_o    <= d_we_i;
              mem_sel_o   <= d_sel_i;
              mem_addr_o  <= d_addr_i;
              mem_wdata_o <= d_wdata_i;
            end else begin
              // Fetches never write; write data keeps its previous value.
              cur_grant  <= ARB_GRANT_IF;
              last_grant <= ARB_GRANT_IF;
              mem_we_o   <= WRITE_DISABLE;
              mem_sel_o  <= SEL_ALL;
              mem_addr_o <= if_addr_i;
            end
          end
        end
        ARB_ACCESS: begin
          if (cnt_zero) begin
            state    <= ARB_IDLE;
            mem_ce_o <= CHIP_DISABLE;
            mem_we_o <= WRITE_DISABLE;
            if (cur_grant == ARB_GRANT_DATA) begin
              d_ack_o <= 1'b1;
              if (mem_we_o == WRITE_DISABLE) begin
                d_rdata_o <= mem_rdata_i;
              end
            end else begin
              if_ack_o   <= 1'b1;
              if_rdata_o <= mem_rdata_i;
            end
          end
        end
        default: begin
          state    <= ARB_IDLE;
          mem_ce_o <= CHIP_DISABLE;
          mem_we_o <= WRITE_DISABLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic idle_grant;
  assign idle_grant = (state == ARB_IDLE) & grant_any;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      if_grant_cnt_o <= '0;
      d_grant_cnt_o  <= '0;
      conflict_cnt_o <= '0;
    end else begin
      if (idle_grant && !grant_data && (if_grant_cnt_o != 32'hFFFF_FFFF)) begin
        if_grant_cnt_o <= if_grant_cnt_o + 32'd1;
      end
      if (idle_grant && grant_data && (d_grant_cnt_o != 32'hFFFF_FFFF)) begin
        d_grant_cnt_o <= d_grant_cnt_o + 32'd1;
      end
      if ((state == ARB_IDLE) && if_elig && d_elig && (conflict_cnt_o != 32'hFFFF_FFFF)) begin
        conflict_cnt_o <= conflict_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed latency/priority/reset cases
// plus randomized concurrent fetch and data traffic against a reference memory.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WC = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_sel;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          stallreq;
  logic          mem_ce;
  logic          mem_we;
  logic [3:0]    mem_sel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [31:0]   if_gcnt;
  logic [31:0]   d_gcnt;
  logic [31:0]   conf_cnt;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(WC)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_rdata_o  (if_rdata),
    .if_ack_o    (if_ack),
    .d_req_i     (d_req),
    .d_we_i      (d_we),
    .d_sel_i     (d_sel),
    .d_addr_i    (d_addr),
    .d_wdata_i   (d_wdata),
    .d_rdata_o   (d_rdata),
    .d_ack_o     (d_ack),
    .stallreq_o  (stallreq),
    .mem_ce_o    (mem_ce),
    .mem_we_o    (mem_we),
    .mem_sel_o   (mem_sel),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
`ifdef MEM_ARB_STATS_EN
    ,
    .if_grant_cnt_o (if_gcnt),
    .d_grant_cnt_o  (d_gcnt),
    .conflict_cnt_o (conf_cnt)
`endif
  );

  // Simulated memory driven by the DUT, and an independent reference copy
  // updated by the stimulus when a write is issued.
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_ce && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_sel[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Scoreboard
  typedef struct {
    logic        we;
    logic [31:0] dat;
  } d_exp_t;

  logic [31:0] if_q [$];
  d_exp_t      d_q  [$];
  logic [31:0] d_last;
  byte         grant_log [$];

  always @(negedge clk) begin
    if (!rst) begin
      check("stallreq", {31'd0, stallreq}, {31'd0, (if_req & ~if_ack) | (d_req & ~d_ack)});
      if (if_ack) begin
        grant_log.push_back("F");
        if (if_q.size() == 0) fail_now("unexpected_if_ack");
        else check("if_rdata", if_rdata, if_q.pop_front());
      end
      if (d_ack) begin
        grant_log.push_back("D");
        if (d_q.size() == 0) fail_now("unexpected_d_ack");
        else begin
          d_exp_t e;
          e = d_q.pop_front();
          if (e.we) check("d_rdata_after_write", d_rdata, d_last);
          else begin
            check("d_rdata", d_rdata, e.dat);
            d_last = e.dat;
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    if_q.delete();
    d_q.delete();
    grant_log.delete();
    d_last = '0;
  endtask

  task automatic fetch_txn(input logic [7:0] w);
    int k;
    if_q.push_back(ref_mem[w]);
    @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = {22'd0, w, 2'b00};
    k = 0;
    do begin @(negedge clk); k++; end while (!if_ack && k < 200);
    if (!if_ack) fail_now("fetch_ack_timeout");
    @(posedge clk);
    #1;
    if_req = 1'b0;
  endtask

  task automatic data_txn(input logic we, input logic [7:0] w, input logic [3:0] sel,
                          input logic [31:0] wd);
    int k;
    d_exp_t e;
    e.we = we;
    e.dat = ref_mem[w];
    if (we) ref_mem[w] = merge(ref_mem[w], wd, sel);
    d_q.push_back(e);
    @(posedge clk);
    #1;
    d_req = 1'b1; d_we = we; d_sel = sel; d_addr = {22'd0, w, 2'b00}; d_wdata = wd;
    k = 0;
    do begin @(negedge clk); k++; end while (!d_ack && k < 200);
    if (!d_ack) fail_now("data_ack_timeout");
    @(posedge clk);
    #1;
    d_req = 1'b0;
  endtask

  logic ce_s [0:31];
  logic ack_s [0:31];
  logic st_s [0:31];

  initial begin
    int good, k, fa, da;
    logic [31:0] wv;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] s_if, s_d, s_c;
`endif
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_sel = 4'h0; d_addr = '0; d_wdata = '0; d_last = '0;
    for (int i = 0; i < 256; i++) begin
      wv = $urandom;
      mem[i] = wv;
      ref_mem[i] = wv;
    end
    mem[1] = 32'h3C01_1234;
    ref_mem[1] = 32'h3C01_1234;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_mem_ce", {31'd0, mem_ce}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_sel", {28'd0, mem_sel}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);

    // Single fetch: latency, stall window, then no re-grant while req is held through ack
    if_q.push_back(32'h3C01_1234);
    @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = 32'h0000_0004;
    for (int i = 0; i < WC + 7; i++) begin
      @(negedge clk);
      ce_s[i] = mem_ce; ack_s[i] = if_ack; st_s[i] = stallreq;
      @(posedge clk);
      #1;
      if (ack_s[i]) if_req = 1'b0;
    end
    for (int i = 0; i < WC + 7; i++) begin
      check($sformatf("fetch_ce_c%0d", i), {31'd0, ce_s[i]}, {31'd0, (i >= 1 && i <= 1 + WC)});
      check($sformatf("fetch_ack_c%0d", i), {31'd0, ack_s[i]}, {31'd0, (i == 2 + WC)});
      check($sformatf("fetch_stall_c%0d", i), {31'd0, st_s[i]}, {31'd0, (i <= 1 + WC)});
    end

    // Partial write: memory-side signals and duration
    wv = ref_mem[130];
    ref_mem[130] = merge(wv, 32'hDEAD_BEEF, 4'b0011);
    d_q.push_back('{we: 1'b1, dat: 32'd0});
    @(posedge clk);
    #1;
    d_req = 1'b1; d_we = 1'b1; d_sel = 4'b0011; d_addr = 32'd520; d_wdata = 32'hDEAD_BEEF;
    good = 0; k = 0;
    do begin
      @(negedge clk);
      k++;
      if (mem_ce && mem_we && mem_sel == 4'b0011 && mem_wdata == 32'hDEAD_BEEF && mem_addr == 32'd520)
        good++;
    end while (!d_ack && k < 50);
    check("write_cycles", good, WC + 1);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    data_txn(1'b0, 8'd130, 4'hF, 32'd0);

    // Simultaneous requests after reset: strict D,F,D,F alternation
    do_reset();
`ifdef MEM_ARB_STATS_EN
    @(negedge clk);
    check("stats_rst_if", if_gcnt, 32'd0);
    check("stats_rst_d", d_gcnt, 32'd0);
    check("stats_rst_conf", conf_cnt, 32'd0);
    s_if = if_gcnt; s_d = d_gcnt; s_c = conf_cnt;
`endif
    if_q.push_back(ref_mem[2]);
    if_q.push_back(ref_mem[2]);
    d_q.push_back('{we: 1'b0, dat: ref_mem[140]});
    d_q.push_back('{we: 1'b0, dat: ref_mem[140]});
    @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = 32'd8;
    d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'd560;
    fa = 0; da = 0; k = 0;
    while ((fa < 2 || da < 2) && k < 100) begin
      @(negedge clk);
      k++;
      if (if_ack) fa++;
      if (d_ack) da++;
      @(posedge clk);
      #1;
      if (fa >= 2) if_req = 1'b0;
      if (da >= 2) d_req = 1'b0;
    end
    if_req = 1'b0; d_req = 1'b0;
    check("order_len", grant_log.size(), 32'd4);
    if (grant_log.size() == 4) begin
      check("order_0", {24'd0, grant_log[0]}, {24'd0, 8'h44});
      check("order_1", {24'd0, grant_log[1]}, {24'd0, 8'h46});
      check("order_2", {24'd0, grant_log[2]}, {24'd0, 8'h44});
      check("order_3", {24'd0, grant_log[3]}, {24'd0, 8'h46});
    end
`ifdef MEM_ARB_STATS_EN
    @(negedge clk);
    check("stats_if_delta", if_gcnt - s_if, 32'd2);
    check("stats_d_delta", d_gcnt - s_d, 32'd2);
    check("stats_conf_delta", conf_cnt - s_c, 32'd1);
`endif

    // Randomized concurrent traffic; fetch and data use disjoint halves of memory
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          fetch_txn(8'($urandom_range(0, 127)));
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          logic        rw;
          logic [3:0]  sl;
          rw = 1'($urandom_range(0, 1));
          sl = rw ? 4'($urandom_range(1, 15)) : 4'hF;
          data_txn(rw, 8'($urandom_range(128, 255)), sl, $urandom);
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
      end
    join
    repeat (5) @(posedge clk);
    check("if_q_drained", if_q.size(), 32'd0);
    check("d_q_drained", d_q.size(), 32'd0);

    // Reset in the middle of an access: no ack afterwards, outputs cleared
    @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = 32'd12;
    @(posedge clk);
    #1;
    rst = 1'b1; if_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if_q.delete();
    @(negedge clk);
    check("midrst_ce", {31'd0, mem_ce}, 32'd0);
    check("midrst_addr", mem_addr, 32'd0);
    check("midrst_sel", {28'd0, mem_sel}, 32'd0);
    check("midrst_if_rdata", if_rdata, 32'd0);
    good = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_ack || d_ack || mem_ce) good++;
    end
    check("midrst_no_activity", good, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port instruction/data memory between the core's fetch port and its load/store port.
- Sits between openmips and the memory inside openmips_min_sopc.
- Serialises requests with data-over-fetch priority plus a starvation guard; inserts a configurable number of wait states.
- Raises a stall request to the pipeline controller while any request is outstanding.

Parameters:
- ADDR_W, 32, address width (matches the instruction address bus)
- DATA_W, 32, data width (matches the instruction bus)
- WAIT_CYC, 1, extra memory wait cycles per access; legal range 0..15

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch request; requester holds it until if_ack_o
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched instruction, registered
- if_ack_o  out  1  one-cycle fetch completion pulse
- d_req_i  in  1  data request; requester holds it until d_ack_o
- d_we_i  in  1  1 = write, 0 = read
- d_sel_i  in  4  byte enables
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  write data
- d_rdata_o  out  DATA_W  load data, registered
- d_ack_o  out  1  one-cycle data completion pulse
- stallreq_o  out  1  pipeline stall request
- mem_ce_o  out  1  memory chip enable
- mem_we_o  out  1  memory write enable
- mem_sel_o  out  4  memory byte enables
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data (combinational read)

Behaviour:
- Reset (rst = 1 at a clk edge): state IDLE; all outputs 0; wait counter 0; last_grant = fetch.
- Reset mid-access aborts the access. No ack is produced for it.
- FSM states: IDLE, ACCESS.
- IDLE, eligibility: a port is eligible if its req is 1 and its ack_o is 0 this cycle. This stops a requester that is still holding req during its ack cycle from being re-granted.
- IDLE, arbitration:
  - Data wins if eligible.
  - Exception: if last_grant = data and fetch is eligible, fetch wins (starvation guard).
  - The winner's address, we, sel and wdata are latched; last_grant is updated; counter loads WAIT_CYC; next state ACCESS.
- ACCESS:
  - mem_ce_o = 1; mem_addr_o, mem_we_o, mem_sel_o and mem_wdata_o are driven from the latched values and held stable.
  - For a fetch grant: mem_we_o = 0 and mem_sel_o = 4'hF.
  - Counter decrements each cycle.
  - In the cycle the counter reads 0:
    - on a read, mem_rdata_i is captured into the granted port's rdata_o;
    - that port's ack_o is set for the next cycle;
    - next state IDLE.
- Latency: request first seen in IDLE at cycle N gives mem_ce_o = 1 in cycles N+1..N+1+WAIT_CYC and ack_o = 1 in cycle N+2+WAIT_CYC.
- Throughput: one access per WAIT_CYC+2 cycles. The ack cycle doubles as the next arbitration cycle.
- mem_ce_o = 0 in IDLE. Memory outputs hold their last values except mem_ce_o and mem_we_o, which are 0 in IDLE.
- Writes: ack timing is identical to reads; d_rdata_o is unchanged.
- Dropped request: if req falls during ACCESS, the access still completes and ack still pulses (no abort). Requesters ignore unexpected acks.
- Simultaneous fetch and data requests in IDLE: resolved by the priority and starvation-guard rule above. The loser stays pending.
- rdata_o holds its value until the next ack on the same port.
- stallreq_o (combinational) = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o).

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined: adds three 32-bit output ports, if_grant_cnt_o, d_grant_cnt_o and conflict_cnt_o.
  - Each grant increments the counter for its port.
  - conflict_cnt_o increments on each IDLE cycle where both ports are eligible.
  - All three counters saturate at 32'hFFFFFFFF and clear on rst.
- Undefined: these ports and counters are absent. Core behaviour is identical with or without the macro.

Decomposition:
- define.v gains `ArbIdle` and `ArbAccess` (1-bit state encodings) and `ArbGrantIf` and `ArbGrantData` (last_grant encodings).
- Existing `InstAddrBus`, `InstBus`, `RstEnable`, `ChipEnable` and `WriteEnable` constants are reused.
- One natural sub-module: arb_wait_cnt, a loadable 4-bit down-counter with load, decrement and zero-flag outputs.
- Everything else lives in mem_arbiter.

Test Plan:
- WAIT_CYC = 1; single fetch, if_req_i = 1 at cycle 2 with addr 0x00000004 and mem returning 0x3C011234 → mem_ce_o = 1 in cycles 3–4; if_ack_o = 1 at cycle 5; if_rdata_o = 0x3C011234; stallreq_o = 1 in cycles 2–4.
- Both requests raised in the same cycle with fetch held continuously → data granted first, then fetch, then data (starvation guard). Grant order is D, F, D, F…; neither port waits more than one access.
- Data write, d_sel_i = 4'b0011, wdata = 0xDEADBEEF → mem_we_o = 1, mem_sel_o = 4'b0011, mem_wdata_o = 0xDEADBEEF for WAIT_CYC+1 cycles; d_ack_o pulses; d_rdata_o unchanged.
- rst asserted in the middle of ACCESS → next cycle IDLE, all outputs 0; no ack appears later.
- Requester keeps if_req_i = 1 through its ack cycle, then drops it → no second grant issued; mem_ce_o = 0 afterwards.
- With MEM_ARB_STATS_EN: 3 conflicting cycles and 5 fetch grants → conflict_cnt_o = 3, if_grant_cnt_o = 5; both counters read 0 after rst.
